// File: rtl/gray_lbp_host.sv
// Host-side responder for the LBP engine: serves gray pixels from an image RAM
// and captures LBP results into a result RAM with write statistics and error flags.
module gray_lbp_host #(
    parameter int AW    = 14,
    parameter int DW    = 8,
    parameter int IMG_W = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          img_we,
    input  logic [AW-1:0] img_waddr,
    input  logic [DW-1:0] img_wdata,
    input  logic          start,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    input  logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_data,
    output logic          done,
    output logic [AW:0]   wr_cnt,
    output logic          border_err,
    output logic          dup_err
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            gray_ready_q, done_q;
    logic [DW-1:0]   gray_data_q, res_data_q;
    logic [AW:0]     wr_cnt_q, wr_cnt_d;
    logic            border_err_q, border_err_d;
    logic            dup_err_q, dup_err_d;
    logic [DEPTH-1:0] written_q;
    logic            lbp_we_s;

    logic [DW-1:0] img_ram [DEPTH];
    logic [DW-1:0] lbp_ram [DEPTH];

    // Pixels in the first/last row or first/last column have no full 3x3 neighbourhood.
    function automatic logic is_border(input logic [AW-1:0] a);
        logic [AW-1:0] col;
        col = a % AW'(IMG_W);
        return (a < AW'(IMG_W)) || (a >= AW'(DEPTH - IMG_W)) ||
               (col == {AW{1'b0}}) || (col == AW'(IMG_W - 1));
    endfunction

    assign lbp_we_s = (state_q == ST_SERVE) && lbp_valid;

    // Next-state logic for the run controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SERVE;
                else       state_d = ST_IDLE;
            end
            ST_SERVE: begin
                if (finish) state_d = ST_DONE;
                else        state_d = ST_SERVE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the write statistics and sticky error flags.
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        border_err_d = border_err_q;
        dup_err_d    = dup_err_q;
        if (lbp_we_s) begin
            if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + {{AW{1'b0}}, 1'b1};
            else                     wr_cnt_d = wr_cnt_q;
            if (is_border(lbp_addr)) border_err_d = 1'b1;
            else                     border_err_d = border_err_q;
            if (written_q[lbp_addr]) dup_err_d = 1'b1;
            else                     dup_err_d = dup_err_q;
        end else begin
            wr_cnt_d     = wr_cnt_q;
            border_err_d = border_err_q;
            dup_err_d    = dup_err_q;
        end
    end

    // Controller state and status registers; outputs decode from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gray_ready_q <= 1'b0;
            done_q       <= 1'b0;
            wr_cnt_q     <= {(AW+1){1'b0}};
            border_err_q <= 1'b0;
            dup_err_q    <= 1'b0;
            res_data_q   <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            gray_ready_q <= (state_d == ST_SERVE);
            done_q       <= (state_d == ST_DONE);
            wr_cnt_q     <= wr_cnt_d;
            border_err_q <= border_err_d;
            dup_err_q    <= dup_err_d;
            res_data_q   <= lbp_ram[res_addr];
        end
    end

    // Per-address written flags used for duplicate detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written_q <= {DEPTH{1'b0}};
        end else if (lbp_we_s) begin
            written_q[lbp_addr] <= 1'b1;
        end
    end

    // Image RAM is host-writable only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && img_we) img_ram[img_waddr] <= img_wdata;
    end

    // Result RAM capture.
    always_ff @(posedge clk) begin
        if (lbp_we_s) lbp_ram[lbp_addr] <= lbp_data;
    end

    // Falling-edge read so a request made at one posedge is ready by the next.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            gray_data_q <= {DW{1'b0}};
        end else if ((state_q == ST_SERVE) && gray_req) begin
            gray_data_q <= img_ram[gray_addr];
        end
    end

    assign gray_ready = gray_ready_q;
    assign gray_data  = gray_data_q;
    assign res_data   = res_data_q;
    assign done       = done_q;
    assign wr_cnt     = wr_cnt_q;
    assign border_err = border_err_q;
    assign dup_err    = dup_err_q;

endmodule
